id_ex_stage: RTL

//  ID/EX pipeline register with integrated load-use hazard detection.

---
 rtl/id_ex_stage.sv | 92 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble insertion on stall/flush and a saturating bubble counter.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [8:0]       id_ctrl,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [DW-1:0]    id_pc4,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  output logic [8:0]       ex_ctrl,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_pc4,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [8:0]       ctrl_q, ctrl_d;
  logic [DW-1:0]    rs_data_q, rt_data_q;
  logic [DW-1:0]    imm_q, pc4_q;
  logic [4:0]       rs_q, rt_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;
  logic             bubble;
  logic             rt_hit;

  // $0 is hardwired zero, so a load into it never creates a hazard
  assign rt_hit = (rt_q == id_rs) | (rt_q == id_rt);
  assign stall  = ctrl_q[5] & (rt_q != 5'd0) & rt_hit;
  assign bubble = flush | stall;

  assign pc_write    = ~(stall & ~flush);
  assign if_id_write = ~(stall & ~flush);

  always_comb begin
    ctrl_d = id_ctrl;
    cnt_d  = cnt_q;
    if (bubble) begin
      ctrl_d = 9'd0;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      pc4_q     <= id_pc4;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_ctrl    = ctrl_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign bubble_cnt = cnt_q;

endmodule
